// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : two-port (fetch / data) arbiter onto one big-endian memory.
// Optional ARB_FAIR_EN: round-robin tie-break instead of fixed D-over-I.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_ack,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_size,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   hold_addr_q, hold_addr_d;
  logic [3:0]          hold_be_q, hold_be_d;
  logic [31:0]         hold_wdata_q, hold_wdata_d;
  logic                hold_we_q, hold_we_d;
  logic                hold_err_q, hold_err_d;
  logic                hold_size_q, hold_size_d;
  logic [1:0]          hold_lane_q, hold_lane_d;
  logic                i_ack_q, i_ack_d;
  logic [31:0]         i_rdata_q, i_rdata_d;
  logic                d_ack_q, d_ack_d;
  logic [31:0]         d_rdata_q, d_rdata_d;
  logic                d_err_q, d_err_d;

  logic        i_elig, d_elig, grant_i, grant_d, tie_d;
  logic        i_bad, d_bad;
  logic [3:0]  d_be;
  logic [31:0] d_wd;
  logic [7:0]  lane_byte;
  logic        serving;

`ifdef ARB_FAIR_EN
  // 0 = fetch granted most recently, 1 = data granted most recently
  logic last_grant_q, last_grant_d;
  assign tie_d = ~last_grant_q;
`else
  assign tie_d = 1'b1;
`endif

  always_comb begin
    i_elig  = i_req && (state_q != SERVE_I);
    d_elig  = d_req && (state_q != SERVE_D);
    grant_d = d_elig && (!i_elig || tie_d);
    grant_i = i_elig && !grant_d;

    i_bad = (i_addr[1:0] != 2'b00) || ((i_addr >> ADDR_W) != 32'd0);
    d_bad = (!d_size && (d_addr[1:0] != 2'b00)) || ((d_addr >> ADDR_W) != 32'd0);
    d_be  = d_size ? (4'b1000 >> d_addr[1:0]) : 4'b1111;
    d_wd  = d_size ? {4{d_wdata[7:0]}} : d_wdata;

    case (hold_lane_q)
      2'd0:    lane_byte = mem_rdata[31:24];
      2'd1:    lane_byte = mem_rdata[23:16];
      2'd2:    lane_byte = mem_rdata[15:8];
      default: lane_byte = mem_rdata[7:0];
    endcase
  end

  always_comb begin
    state_d      = IDLE;
    hold_addr_d  = hold_addr_q;
    hold_be_d    = hold_be_q;
    hold_wdata_d = hold_wdata_q;
    hold_we_d    = hold_we_q;
    hold_err_d   = hold_err_q;
    hold_size_d  = hold_size_q;
    hold_lane_d  = hold_lane_q;
`ifdef ARB_FAIR_EN
    last_grant_d = last_grant_q;
`endif

    if (grant_d) begin
      state_d      = SERVE_D;
      hold_addr_d  = {d_addr[ADDR_W-1:2], 2'b00};
      hold_be_d    = d_be;
      hold_wdata_d = d_wd;
      hold_we_d    = d_we;
      hold_err_d   = d_bad;
      hold_size_d  = d_size;
      hold_lane_d  = d_addr[1:0];
`ifdef ARB_FAIR_EN
      last_grant_d = 1'b1;
`endif
    end else if (grant_i) begin
      state_d      = SERVE_I;
      hold_addr_d  = {i_addr[ADDR_W-1:2], 2'b00};
      hold_be_d    = 4'b1111;
      hold_wdata_d = 32'd0;
      hold_we_d    = 1'b0;
      hold_err_d   = i_bad;
      hold_size_d  = 1'b0;
      hold_lane_d  = 2'd0;
`ifdef ARB_FAIR_EN
      last_grant_d = 1'b0;
`endif
    end

    // Responses are captured at the edge that ends the serve cycle.
    i_ack_d   = (state_q == SERVE_I);
    i_rdata_d = i_rdata_q;
    if (state_q == SERVE_I)
      i_rdata_d = hold_err_q ? 32'd0 : mem_rdata;

    d_ack_d   = (state_q == SERVE_D);
    d_err_d   = (state_q == SERVE_D) && hold_err_q;
    d_rdata_d = d_rdata_q;
    if (state_q == SERVE_D) begin
      if (hold_err_q)
        d_rdata_d = 32'd0;
      else if (hold_size_q)
        d_rdata_d = {24'd0, lane_byte};
      else
        d_rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      hold_addr_q  <= '0;
      hold_be_q    <= 4'd0;
      hold_wdata_q <= 32'd0;
      hold_we_q    <= 1'b0;
      hold_err_q   <= 1'b0;
      hold_size_q  <= 1'b0;
      hold_lane_q  <= 2'd0;
      i_ack_q      <= 1'b0;
      i_rdata_q    <= 32'd0;
      d_ack_q      <= 1'b0;
      d_rdata_q    <= 32'd0;
      d_err_q      <= 1'b0;
`ifdef ARB_FAIR_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      hold_addr_q  <= hold_addr_d;
      hold_be_q    <= hold_be_d;
      hold_wdata_q <= hold_wdata_d;
      hold_we_q    <= hold_we_d;
      hold_err_q   <= hold_err_d;
      hold_size_q  <= hold_size_d;
      hold_lane_q  <= hold_lane_d;
      i_ack_q      <= i_ack_d;
      i_rdata_q    <= i_rdata_d;
      d_ack_q      <= d_ack_d;
      d_rdata_q    <= d_rdata_d;
      d_err_q      <= d_err_d;
`ifdef ARB_FAIR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign serving   = (state_q != IDLE);
  assign busy      = serving;
  assign mem_addr  = serving ? hold_addr_q  : '0;
  assign mem_be    = serving ? hold_be_q    : 4'd0;
  assign mem_wdata = serving ? hold_wdata_q : 32'd0;
  // Reset gates the strobe combinationally so a store caught by reset never lands.
  assign mem_we    = (state_q == SERVE_D) & hold_we_q & ~hold_err_q & ~reset;

  assign i_ack   = i_ack_q;
  assign i_rdata = i_rdata_q;
  assign d_ack   = d_ack_q;
  assign d_rdata = d_rdata_q;
  assign d_err   = d_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : scoreboard bench for mem_arbiter with a byte-array memory.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we, d_size;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_ack, d_ack, d_err, mem_we, busy;
  logic [31:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_be;
  logic        tb_init;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        chk_rd;
  } d_exp_t;

  logic [31:0] sb_i[$];
  d_exp_t      sb_d[$];

  logic [7:0] mem [0:1023];

  mem_arbiter #(.ADDR_W(10)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  assign mem_rdata = {mem[int'(mem_addr)], mem[int'(mem_addr) + 1],
                      mem[int'(mem_addr) + 2], mem[int'(mem_addr) + 3]};

  always @(posedge clk) begin
    if (tb_init) begin
      for (int k = 0; k < 1024; k++) mem[k] <= 8'h00;
      mem[16'h10] <= 8'h20; mem[16'h11] <= 8'h08;
      mem[16'h12] <= 8'h00; mem[16'h13] <= 8'h05;
      mem[16'h20] <= 8'h11; mem[16'h21] <= 8'h22;
      mem[16'h22] <= 8'h33; mem[16'h23] <= 8'h44;
    end else if (mem_we) begin
      if (mem_be[3]) mem[int'(mem_addr)]     <= mem_wdata[31:24];
      if (mem_be[2]) mem[int'(mem_addr) + 1] <= mem_wdata[23:16];
      if (mem_be[1]) mem[int'(mem_addr) + 2] <= mem_wdata[15:8];
      if (mem_be[0]) mem[int'(mem_addr) + 3] <= mem_wdata[7:0];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Response monitor: pops the scoreboard whenever an ack is presented.
  always @(negedge clk) begin
    if (!reset && i_ack) begin
      if (sb_i.size() == 0) chk("i_ack_unexpected", 32'd1, 32'd0);
      else chk("i_rdata", i_rdata, sb_i.pop_front());
    end
    if (!reset && d_ack) begin
      if (sb_d.size() == 0) chk("d_ack_unexpected", 32'd1, 32'd0);
      else begin
        d_exp_t e;
        e = sb_d.pop_front();
        chk("d_err", {31'd0, d_err}, {31'd0, e.err});
        if (e.chk_rd) chk("d_rdata", d_rdata, e.rdata);
      end
    end
  end

  task automatic fetch(input logic [31:0] a, input logic [9:0] exp_ma, input logic [31:0] exp);
    int n;
    sb_i.push_back(exp);
    i_addr = a;
    i_req  = 1'b1;
    @(posedge clk); #1;
    n = 1;
    chk("fetch_busy", {31'd0, busy}, 32'd1);
    chk("fetch_maddr", {22'd0, mem_addr}, {22'd0, exp_ma});
    chk("fetch_be", {28'd0, mem_be}, 32'hf);
    while (!i_ack && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("fetch_latency", n, 2);
    i_req = 1'b0;
  endtask

  task automatic dop(input logic we, input logic sz, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] exp_rd,
                     input logic exp_err, input logic chk_rd,
                     input logic [9:0] exp_ma, input logic [3:0] exp_be,
                     input logic [31:0] exp_mwd, input logic exp_we);
    int n;
    d_exp_t e;
    e.rdata = exp_rd; e.err = exp_err; e.chk_rd = chk_rd;
    sb_d.push_back(e);
    d_we = we; d_size = sz; d_addr = a; d_wdata = wd;
    d_req = 1'b1;
    @(posedge clk); #1;
    n = 1;
    chk("d_maddr", {22'd0, mem_addr}, {22'd0, exp_ma});
    chk("d_be", {28'd0, mem_be}, {28'd0, exp_be});
    chk("d_mwdata", mem_wdata, exp_mwd);
    chk("d_mwe", {31'd0, mem_we}, {31'd0, exp_we});
    while (!d_ack && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("d_latency", n, 2);
    d_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn, inn;
    reset = 1'b1; tb_init = 1'b1;
    i_req = 0; d_req = 0; d_we = 0; d_size = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; tb_init = 1'b0;

    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_i_ack", {31'd0, i_ack}, 32'd0);
    chk("rst_d_ack", {31'd0, d_ack}, 32'd0);
    chk("rst_d_err", {31'd0, d_err}, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_mem_bus", {mem_we, mem_be, mem_addr, 17'd0}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);

    fetch(32'h10, 10'h10, 32'h20080005);
    fetch(32'h12, 10'h10, 32'h0);
    fetch(32'h410, 10'h10, 32'h0);

    //   we sz addr      wdata         exp_rd        err rd  ma      be       mwdata        we
    dop(1, 1, 32'h21,  32'h000000AB, 32'h0,        0, 0, 10'h20, 4'b0100, 32'hABABABAB, 1);
    dop(0, 1, 32'h21,  32'h0,        32'h000000AB, 0, 1, 10'h20, 4'b0100, 32'h0,        0);
    dop(0, 1, 32'h23,  32'h0,        32'h00000044, 0, 1, 10'h20, 4'b0001, 32'h0,        0);
    dop(1, 0, 32'h40,  32'hDEADBEEF, 32'h0,        0, 0, 10'h40, 4'b1111, 32'hDEADBEEF, 1);
    dop(0, 0, 32'h40,  32'h0,        32'hDEADBEEF, 0, 1, 10'h40, 4'b1111, 32'h0,        0);
    dop(0, 0, 32'h20,  32'h0,        32'h11AB3344, 0, 1, 10'h20, 4'b1111, 32'h0,        0);
    dop(0, 0, 32'h22,  32'h0,        32'h0,        1, 1, 10'h20, 4'b1111, 32'h0,        0);
    dop(1, 0, 32'h22,  32'h55AA55AA, 32'h0,        1, 1, 10'h20, 4'b1111, 32'h55AA55AA, 0);
    dop(0, 0, 32'h20,  32'h0,        32'h11AB3344, 0, 1, 10'h20, 4'b1111, 32'h0,        0);
    dop(0, 0, 32'h400, 32'h0,        32'h0,        1, 1, 10'h00, 4'b1111, 32'h0,        0);
    dop(1, 1, 32'h401, 32'h00000077, 32'h0,        1, 1, 10'h00, 4'b0100, 32'h77777777, 0);
    dop(0, 0, 32'h0,   32'h0,        32'h0,        0, 1, 10'h00, 4'b1111, 32'h0,        0);

    // Simultaneous requests straight after reset: D first, then I back-to-back.
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb_i.push_back(32'h20080005);
    sb_d.push_back('{rdata: 32'hDEADBEEF, err: 1'b0, chk_rd: 1'b1});
    i_addr = 32'h10; i_req = 1'b1;
    d_we = 0; d_size = 0; d_addr = 32'h40; d_wdata = 0; d_req = 1'b1;
    dn = 0; inn = 0;
    for (int n = 1; n <= 10 && (dn == 0 || inn == 0); n++) begin
      @(posedge clk); #1;
      if (n == 1) chk("tie_first_maddr", {22'd0, mem_addr}, 32'h40);
      if (n == 2) chk("tie_second_maddr", {22'd0, mem_addr}, 32'h10);
      if (d_ack && dn == 0) begin dn = n; d_req = 1'b0; end
      if (i_ack && inn == 0) begin inn = n; i_req = 1'b0; end
    end
    chk("tie_d_ack_cycle", dn, 2);
    chk("tie_i_ack_cycle", inn, 3);

    // Reset landing on a SERVE_D store: no write, no ack.
    @(posedge clk); #1;
    d_we = 1; d_size = 0; d_addr = 32'h80; d_wdata = 32'h12345678; d_req = 1'b1;
    @(posedge clk); #1;
    chk("rstst_we_before", {31'd0, mem_we}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rstst_we_gated", {31'd0, mem_we}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; d_req = 1'b0;
    chk("rstst_busy", {31'd0, busy}, 32'd0);
    chk("rstst_d_ack", {31'd0, d_ack}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    dop(0, 0, 32'h80, 32'h0, 32'h0, 0, 1, 10'h80, 4'b1111, 32'h0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("sb_i_empty", sb_i.size(), 0);
    chk("sb_d_empty", sb_d.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
